serial_flag_tx: RTL and testbench

Serial framing transmitter: it accepts a parallel word over a valid/ready handshake and sends it MSB-first on a single-bit line. Each frame starts with the flag pattern 1110. The payload is bit-stuffed so it never contains three consecutive 1s. A downstream "three-or-more 1s then 0" sequence detector therefore fires exactly once per frame, on the flag's final 0. The block is the transmit end of the serial link whose receive end uses that detector.

---
 rtl/serial_flag_tx.sv | 108 ++++++++++
 tb/tb_serial_flag_tx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/serial_flag_tx.sv
// Serial framing transmitter: 1110 flag, then MSB-first payload with a stuff 0
// after every "11" pair so the payload never carries three consecutive 1s.
module serial_flag_tx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid,
  output logic              ready,
  output logic              out,
  output logic              frame_active,
  output logic              stuff_bit
);

  localparam int CW = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, FLAG, DATA, STUFF} state_t;

  state_t            state, state_n;
  logic [1:0]        flag_idx, flag_idx_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              ones_cnt, ones_cnt_n;
  logic              out_n;

  assign ready = (state == IDLE) && !rst;

  // state describes the bit currently on out; out_n is the bit for state_n
  always_comb begin
    state_n    = state;
    flag_idx_n = flag_idx;
    shreg_n    = shreg;
    cnt_n      = cnt;
    ones_cnt_n = ones_cnt;
    out_n      = 1'b0;
    case (state)
      IDLE: begin
        if (valid && ready) begin
          state_n    = FLAG;
          flag_idx_n = '0;
          shreg_n    = data_in;
          ones_cnt_n = 1'b0;
          out_n      = 1'b1;
        end
      end
      FLAG: begin
        if (flag_idx == 2'd3) begin
          state_n = DATA;
          cnt_n   = CW'(DATA_W - 1);
          out_n   = shreg[DATA_W-1];
        end else begin
          flag_idx_n = flag_idx + 2'd1;
          out_n      = (flag_idx != 2'd2);
        end
      end
      DATA: begin
        if (shreg[DATA_W-1] && ones_cnt) begin
          state_n    = STUFF;
          ones_cnt_n = 1'b0;
        end else begin
          ones_cnt_n = shreg[DATA_W-1];
          if (cnt != '0) begin
            cnt_n   = cnt - 1'b1;
            shreg_n = shreg << 1;
            out_n   = shreg[DATA_W-2];
          end else begin
            state_n = IDLE;
          end
        end
      end
      STUFF: begin
        if (cnt != '0) begin
          state_n = DATA;
          cnt_n   = cnt - 1'b1;
          shreg_n = shreg << 1;
          out_n   = shreg[DATA_W-2];
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      flag_idx     <= '0;
      shreg        <= '0;
      cnt          <= '0;
      ones_cnt     <= 1'b0;
      out          <= 1'b0;
      frame_active <= 1'b0;
      stuff_bit    <= 1'b0;
    end else begin
      state        <= state_n;
      flag_idx     <= flag_idx_n;
      shreg        <= shreg_n;
      cnt          <= cnt_n;
      ones_cnt     <= ones_cnt_n;
      out          <= out_n;
      frame_active <= (state_n != IDLE);
      stuff_bit    <= (state_n == STUFF);
    end
  end

endmodule

// File: tb/tb_serial_flag_tx.sv
// Bench for serial_flag_tx: fixed frame vectors, mid-frame reset, and random
// back-to-back frames checked by a frame model and a loopback detector/de-stuffer.
module tb_serial_flag_tx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, valid;
  logic [W-1:0] data_in;
  logic         ready, out, frame_active, stuff_bit;

  serial_flag_tx #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid(valid),
    .ready(ready), .out(out), .frame_active(frame_active), .stuff_bit(stuff_bit)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int fcyc  = 0;
  int pulses = 0;
  int last_pulse_fcyc = 0;
  logic [W-1:0] rx_q[$];
  logic [W-1:0] tx_q[$];
  bit exp_b[$];
  bit exp_s[$];

  // loopback receiver: ">=3 ones then 0" detector plus de-stuffer
  int run = 0, prun = 0, got = 0;
  bit collecting = 0, skip = 0;
  logic [W-1:0] word;
  always @(negedge clk) begin
    if (rst) begin
      run = 0; collecting = 0; skip = 0;
    end else begin
      if (collecting) begin
        if (skip) skip = 0;
        else begin
          word = {word[W-2:0], out};
          got++;
          prun = out ? prun + 1 : 0;
          if (prun == 2) begin skip = 1; prun = 0; end
          if (got == W) begin collecting = 0; rx_q.push_back(word); end
        end
      end
      if (!out && run >= 3) begin
        pulses++;
        last_pulse_fcyc = fcyc;
        collecting = 1; got = 0; prun = 0; skip = 0;
      end
      run = out ? run + 1 : 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // frame built directly from the framing rules
  function automatic void model(input logic [W-1:0] d);
    int r;
    exp_b.delete(); exp_s.delete();
    exp_b = '{1, 1, 1, 0};
    exp_s = '{0, 0, 0, 0};
    r = 0;
    for (int i = W - 1; i >= 0; i--) begin
      exp_b.push_back(d[i]); exp_s.push_back(0);
      r = d[i] ? r + 1 : 0;
      if (r == 2) begin exp_b.push_back(0); exp_s.push_back(1); r = 0; end
    end
  endfunction

  task automatic send(input logic [W-1:0] d, input bit hold, input int abort_at);
    int n, p0;
    n = 0;
    while (!ready && n < 200) begin tick; n++; end
    chk("ready_before_accept", ready, 1);
    valid = 1; data_in = d;
    tick;
    data_in = W'($urandom);
    if (!hold) valid = 0;
    p0 = pulses;
    for (int i = 0; i < exp_b.size(); i++) begin
      fcyc = i + 1;
      if (abort_at == i + 1) begin
        rst = 1;
        tick;
        chk("abort_out", out, 0);
        chk("abort_frame_active", frame_active, 0);
        chk("abort_stuff_bit", stuff_bit, 0);
        chk("abort_ready_in_rst", ready, 0);
        rst = 0;
        #1;
        chk("abort_ready_after", ready, 1);
        fcyc = 0;
        return;
      end
      chk("out", out, exp_b[i]);
      chk("stuff_bit", stuff_bit, exp_s[i]);
      chk("frame_active", frame_active, 1);
      chk("ready_busy", ready, 0);
      tick;
    end
    fcyc = 0;
    chk("idle_out", out, 0);
    chk("idle_frame_active", frame_active, 0);
    chk("idle_ready", ready, 1);
    chk("detector_pulses", pulses - p0, 1);
    chk("detector_cycle", last_pulse_fcyc, 4);
  endtask

  typedef struct {
    logic [7:0]  d;
    int          len;
    logic [15:0] bits;  // frame cycle c is bits[16-c]
    logic [15:0] stf;
  } vec_t;
  vec_t tbl[5];

  initial begin
    int ps;
    tbl[0] = '{8'h00, 12, 16'hE000, 16'h0000};
    tbl[1] = '{8'hFF, 16, 16'hEDB6, 16'h0249};
    tbl[2] = '{8'hB6, 14, 16'hEB30, 16'h0088};
    tbl[3] = '{8'h55, 12, 16'hE550, 16'h0000};
    tbl[4] = '{8'h03, 13, 16'hE030, 16'h0008};

    rst = 1; valid = 1; data_in = 8'hAA;
    for (int k = 0; k < 2; k++) begin
      tick;
      chk("rst_out", out, 0);
      chk("rst_ready", ready, 0);
      chk("rst_frame_active", frame_active, 0);
      chk("rst_stuff_bit", stuff_bit, 0);
    end
    valid = 0; rst = 0;
    #1;
    chk("ready_after_rst", ready, 1);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("no_spurious_frame", frame_active, 0);
      chk("no_spurious_out", out, 0);
    end

    for (int k = 0; k < 5; k++) begin
      exp_b.delete(); exp_s.delete();
      for (int c = 1; c <= tbl[k].len; c++) begin
        exp_b.push_back(tbl[k].bits[16-c]);
        exp_s.push_back(tbl[k].stf[16-c]);
      end
      send(tbl[k].d, 0, 0);
    end

    model(8'hFF);
    send(8'hFF, 0, 7);
    model(8'hFF);
    send(8'hFF, 0, 0);
    model(8'h37);
    send(8'h37, 0, 0);

    rx_q.delete(); tx_q.delete();
    ps = pulses;
    for (int k = 0; k < 100; k++) begin
      logic [W-1:0] d;
      d = W'($urandom);
      tx_q.push_back(d);
      model(d);
      send(d, 1, 0);
    end
    valid = 0;
    tick;
    chk("b2b_pulse_total", pulses - ps, 100);
    chk("rx_count", rx_q.size(), 100);
    for (int k = 0; k < 100; k++)
      if (k < rx_q.size()) chk("rx_word", rx_q[k], tx_q[k]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
